// File: rtl/ucsbece154a_lsu.sv
// ucsbece154a_lsu: load/store unit driving a word-only single-port data memory; optional counters via LSU_PERF_EN
module ucsbece154a_lsu #(
    parameter int ADDR_W = 32,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i
`ifdef LSU_PERF_EN
    ,
    output logic [PERF_W-1:0] ld_cnt_o,
    output logic [PERF_W-1:0] st_cnt_o,
    output logic [PERF_W-1:0] err_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_e;
    state_e state_q, state_d;
    logic we_q, we_d, err_q, err_d;
    logic [2:0] f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, merge_q, merge_d;
    logic bad_cmd;
    logic [7:0] ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val, merge;
    assign bad_cmd = (funct3_i == 3'b011) | (funct3_i[2] & funct3_i[1]) | (we_i & funct3_i[2])
                   | ((funct3_i[1:0] == 2'b01) & addr_i[0])
                   | ((funct3_i[1:0] == 2'b10) & (|addr_i[1:0]));
    assign ld_b = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
    assign ld_h = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    assign ld_val = (f3_q[1:0] == 2'b00) ? {{24{ld_b[7] & ~f3_q[2]}}, ld_b} :
                    (f3_q[1:0] == 2'b01) ? {{16{ld_h[15] & ~f3_q[2]}}, ld_h} : mem_rd_i;
    assign ready_o  = state_q == IDLE;
    assign valid_o  = state_q == DONE;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign mem_a_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wd_o = (state_q == WRITE) ? merge_q : wdata_q;
    assign mem_we_o = rst_ni & ((state_q == WRITE) | ((state_q == ACCESS) & we_q & f3_q[1]));
    // Read word with the store lane replaced for SB/SH read-modify-write
    always_comb begin
        merge = mem_rd_i;
        if (f3_q[0]) merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
    // Command sequencing: accept/validate, memory access, optional merge write, completion
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        case (state_q)
            IDLE: if (req_i) begin
                we_d    = we_i;
                f3_d    = funct3_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                err_d   = bad_cmd;
                rdata_d = bad_cmd ? 32'h0 : rdata_q;
                state_d = bad_cmd ? DONE : ACCESS;
            end
            ACCESS: begin
                rdata_d = we_q ? rdata_q : ld_val;
                merge_d = merge;
                state_d = (we_q & ~f3_q[1]) ? WRITE : DONE;
            end
            WRITE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    // State and command registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end
`ifdef LSU_PERF_EN
    logic [PERF_W-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d, err_cnt_q, err_cnt_d;
    assign ld_cnt_o  = ld_cnt_q;
    assign st_cnt_o  = st_cnt_q;
    assign err_cnt_o = err_cnt_q;
    // Saturating completion counters, bumped while in DONE
    always_comb begin
        ld_cnt_d  = (valid_o & ~err_q & ~we_q & ~&ld_cnt_q) ? ld_cnt_q + PERF_W'(1) : ld_cnt_q;
        st_cnt_d  = (valid_o & ~err_q & we_q & ~&st_cnt_q) ? st_cnt_q + PERF_W'(1) : st_cnt_q;
        err_cnt_d = (valid_o & err_q & ~&err_cnt_q) ? err_cnt_q + PERF_W'(1) : err_cnt_q;
    end
    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            ld_cnt_q  <= ld_cnt_d;
            st_cnt_q  <= st_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_ucsbece154a_lsu.sv
// tb_ucsbece154a_lsu: directed bench with a transaction-level model of the load/store unit
module tb_ucsbece154a_lsu;
    logic clk = 0, rst_ni = 0, req_i = 0, we_i = 0;
    logic [2:0] funct3_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0;
    logic ready_o, valid_o, err_o, mem_we_o;
    logic [31:0] rdata_o, mem_a_o, mem_wd_o, mem_rd_i;
`ifdef LSU_PERF_EN
    logic [15:0] ld_cnt_o, st_cnt_o, err_cnt_o;
`endif
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    int n_cmp = 0, n_bad = 0, n_valid = 0, cyc = 0;
    int m_valid_at = -1, m_free_at = 0, m_ld = 0, m_st = 0, m_er = 0;
    logic chk_on = 0, m_err = 0, p_err = 0, p_store = 0, p_load = 0;
    logic [31:0] m_rdata = 0, m_aw = 0, p_rd = 0, p_wval = 0;

    ucsbece154a_lsu dut (
        .clk(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .valid_o(valid_o),
        .rdata_o(rdata_o), .err_o(err_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o),
        .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
`ifdef LSU_PERF_EN
        , .ld_cnt_o(ld_cnt_o), .st_cnt_o(st_cnt_o), .err_cnt_o(err_cnt_o)
`endif
    );

    always #5 clk = ~clk;
    assign mem_rd_i = mem[mem_a_o[7:2]];
    always @(posedge clk) if (mem_we_o) mem[mem_a_o[7:2]] <= mem_wd_o;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: decide outcome of the command on the inputs using size/alignment arithmetic
    task automatic model_accept(output int lat);
        int sz, sh;
        logic legal;
        logic [31:0] w, v, mask;
        legal = we_i ? (funct3_i inside {3'd0, 3'd1, 3'd2}) : (funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << funct3_i[1:0];
        sh = int'(addr_i[1:0]) * 8;
        p_err = !legal || (addr_i % sz != 0);
        p_load = !we_i && !p_err;
        p_store = we_i && !p_err;
        w = ref_mem[addr_i[7:2]];
        mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
        v = (w >> sh) & mask;
        if (!p_err && !funct3_i[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        p_rd = p_err ? 32'h0 : v;
        p_wval = (w & ~(mask << sh)) | ((wdata_i & mask) << sh);
        m_aw = {addr_i[31:2], 2'b00};
        lat = p_err ? 1 : (we_i && sz < 4) ? 3 : 2;
    endtask

    initial forever begin
        int lat;
        @(posedge clk);
        if (!rst_ni) begin
            cyc++;
            m_valid_at = -1;
            m_free_at = cyc;
            m_rdata = 0;
            m_err = 0;
            m_aw = 0;
            p_store = 0;
            m_ld = 0;
            m_st = 0;
            m_er = 0;
            chk_on = 1;
        end else begin
            if (cyc == m_valid_at) begin
                if (p_err) m_er = (m_er < 65535) ? m_er + 1 : m_er;
                else if (p_store) m_st = (m_st < 65535) ? m_st + 1 : m_st;
                else m_ld = (m_ld < 65535) ? m_ld + 1 : m_ld;
            end
            if (req_i && cyc >= m_free_at) begin
                model_accept(lat);
                m_valid_at = cyc + lat;
                m_free_at = m_valid_at + 1;
            end
            if (cyc + 1 == m_valid_at) begin
                if (p_store) ref_mem[m_aw[7:2]] = p_wval;
                if (p_err || p_load) m_rdata = p_rd;
                m_err = p_err;
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("ready", ready_o, cyc >= m_free_at);
            chk("valid", valid_o, cyc == m_valid_at);
            if (valid_o) begin
                n_valid++;
                chk("err", err_o, m_err);
            end
            chk("rdata", rdata_o, m_rdata);
            chk("mem_we", mem_we_o, p_store && rst_ni && cyc + 1 == m_valid_at);
            chk("mem_a", mem_a_o, m_aw);
            if (mem_we_o) chk("mem_wd", mem_wd_o, p_wval);
            for (int i = 4; i < 6; i++) chk("mem_word", mem[i], ref_mem[i]);
`ifdef LSU_PERF_EN
            chk("ld_cnt", ld_cnt_o, m_ld);
            chk("st_cnt", st_cnt_o, m_st);
            chk("err_cnt", err_cnt_o, m_er);
`endif
        end
    end

    task automatic op(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input int exp_lat);
        int k;
        @(negedge clk);
        #1;
        req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(posedge clk);
        #1 req_i = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid_o && k < 8);
        chk({nm, " latency"}, k, exp_lat);
        chk({nm, " err"}, err_o, exp_lat == 1);
        if (we && exp_lat > 1) chk({nm, " word"}, mem[a[7:2]], exp);
        else chk({nm, " rdata"}, rdata_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 0;
            ref_mem[i] = 0;
        end
        mem[4] = 32'h8765_43A1;
        ref_mem[4] = 32'h8765_43A1;
        repeat (2) @(negedge clk);
        chk("reset ready", ready_o, 1);
        chk("reset valid", valid_o, 0);
        chk("reset rdata", rdata_o, 0);
        chk("reset mem_we", mem_we_o, 0);
        #1 rst_ni = 1;
        op("LW 10", 0, 3'b010, 32'h10, 0, 32'h8765_43A1, 2);
        op("LB 10", 0, 3'b000, 32'h10, 0, 32'hFFFF_FFA1, 2);
        op("LBU 13", 0, 3'b100, 32'h13, 0, 32'h0000_0087, 2);
        op("LH 12", 0, 3'b001, 32'h12, 0, 32'hFFFF_8765, 2);
        op("LHU 10", 0, 3'b101, 32'h10, 0, 32'h0000_43A1, 2);
        op("SB 11", 1, 3'b000, 32'h11, 32'h0000_00CC, 32'h8765_CCA1, 3);
        op("SH 12", 1, 3'b001, 32'h12, 32'h0000_BEEF, 32'hBEEF_CCA1, 3);
        op("SW 14", 1, 3'b010, 32'h14, 32'h1234_5678, 32'h1234_5678, 2);
        op("LB 15", 0, 3'b000, 32'h15, 0, 32'h0000_0056, 2);
        op("SH 13 misaligned", 1, 3'b001, 32'h13, 32'h1111, 32'h0, 1);
        op("LW 16 misaligned", 0, 3'b010, 32'h16, 0, 32'h0, 1);
        op("LW f3=011", 0, 3'b011, 32'h10, 0, 32'h0, 1);
        op("SBU illegal", 1, 3'b100, 32'h10, 32'h77, 32'h0, 1);
        chk("word after errors", mem[4], 32'hBEEF_CCA1);
        @(negedge clk);
        #1;
        req_i = 1; we_i = 1; funct3_i = 3'b000; addr_i = 32'h10; wdata_i = 32'h55;
        @(posedge clk);
        #1 req_i = 0;
        @(posedge clk);
        #1 rst_ni = 0;
        @(posedge clk);
        #1 rst_ni = 1;
        @(negedge clk);
        chk("ready after reset", ready_o, 1);
        chk("word after reset", mem[4], 32'hBEEF_CCA1);
        chk("rdata after reset", rdata_o, 0);
        v0 = n_valid;
        @(negedge clk);
        #1;
        req_i = 1; we_i = 0; funct3_i = 3'b010; addr_i = 32'h10;
        repeat (12) @(negedge clk);
        #1 req_i = 0;
        repeat (4) @(negedge clk);
        chk("stream completions", n_valid - v0, 4);
        chk("stream rdata", rdata_o, 32'hBEEF_CCA1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
